// File: rtl/bgm_pkg.sv
// rtl/bgm_pkg.sv - shared state type, silence word and per-track tables for the BGM sequencer
package bgm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_PLAY,
    ST_DONE
  } bgm_state_t;

  localparam int MAX_TRACKS = 8;
  localparam int DIV_W      = 8;
  localparam int unsigned SILENCE_TONE = 50000000;

  // Tables are built so that BASE + LEN never exceeds the note-ROM depth.
  localparam int TRK_BASE [MAX_TRACKS] = '{0, 8, 16, 32, 40, 64, 100, 4000};
  localparam int TRK_LEN  [MAX_TRACKS] = '{3, 2, 4, 1, 5, 2, 3, 8};
  localparam int TRK_DIV  [MAX_TRACKS] = '{8, 6, 4, 5, 7, 4, 9, 6};
  localparam bit TRK_LOOP [MAX_TRACKS] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/bgm_beat_timer.sv
// rtl/bgm_beat_timer.sv - beat divider counting 0..last with a registered one-cycle beat pulse
module bgm_beat_timer
  import bgm_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_last,
  output logic             o_wrap,
  output logic             o_beat_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;

  // A clear in the wrap cycle suppresses the beat so a restart always wins.
  assign o_wrap      = i_run && !i_clr && (r_cnt == i_last);
  assign o_beat_tick = r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= o_wrap;
      if (i_clr || !i_run || o_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bgm_sequencer.sv
// rtl/bgm_sequencer.sv - background-music sequencer stepping a note ROM per beat for the selected track
module bgm_sequencer
  import bgm_pkg::*;
#(
  parameter int          NUM_TRACKS = 8,
  parameter int          ADDR_W     = 12,
  parameter int          FREQ_W     = 26,
  parameter int unsigned SILENCE    = SILENCE_TONE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [$clog2(NUM_TRACKS)-1:0] track_sel,
  input  logic                          mute,
  output logic                          rom_rd,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [FREQ_W-1:0]             rom_toneL,
  input  logic [FREQ_W-1:0]             rom_toneR,
  output logic [FREQ_W-1:0]             freqL,
  output logic [FREQ_W-1:0]             freqR,
  output logic                          beat_tick,
  output logic                          track_done
);

  localparam int SEL_W = $clog2(NUM_TRACKS);
  localparam logic [FREQ_W-1:0] SIL = FREQ_W'(SILENCE);

  bgm_state_t        r_state;
  logic [SEL_W-1:0]  r_sel_prev;
  logic              r_en_prev;
  logic [ADDR_W-1:0] r_beat;
  logic              r_rom_rd;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [FREQ_W-1:0] r_freq_l;
  logic [FREQ_W-1:0] r_freq_r;
  logic [FREQ_W-1:0] r_hold_l;
  logic [FREQ_W-1:0] r_hold_r;
  logic              r_done;

  logic              w_valid;
  logic              w_restart;
  logic              w_clr;
  logic              w_run;
  logic              w_wrap;
  logic              w_tick;
  logic [DIV_W-1:0]  w_div_last;

  // r_sel_prev is the playing track: any change of track_sel forces a restart.
  assign w_valid    = en && (int'(track_sel) < NUM_TRACKS);
  assign w_restart  = w_valid && ((en && !r_en_prev) || (track_sel != r_sel_prev));
  assign w_clr      = !w_valid || w_restart;
  assign w_run      = (r_state == ST_LOAD) || (r_state == ST_WAIT) || (r_state == ST_PLAY);
  assign w_div_last = DIV_W'(TRK_DIV[r_sel_prev] - 1);

  bgm_beat_timer u_beat_timer (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_clr       (w_clr),
    .i_run       (w_run),
    .i_last      (w_div_last),
    .o_wrap      (w_wrap),
    .o_beat_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_sel_prev <= '0;
      r_en_prev  <= 1'b0;
      r_beat     <= '0;
      r_rom_rd   <= 1'b0;
      r_rom_addr <= '0;
      r_freq_l   <= SIL;
      r_freq_r   <= SIL;
      r_hold_l   <= SIL;
      r_hold_r   <= SIL;
      r_done     <= 1'b0;
    end else begin
      r_en_prev  <= en;
      r_sel_prev <= track_sel;
      r_rom_rd   <= 1'b0;

      // Tone output follows the state held during this cycle; mute only masks it.
      case (r_state)
        ST_LOAD, ST_PLAY: begin
          r_freq_l <= mute ? SIL : r_hold_l;
          r_freq_r <= mute ? SIL : r_hold_r;
        end
        ST_WAIT: begin
          r_hold_l <= rom_toneL;
          r_hold_r <= rom_toneR;
          r_freq_l <= mute ? SIL : rom_toneL;
          r_freq_r <= mute ? SIL : rom_toneR;
        end
        default: begin
          r_freq_l <= SIL;
          r_freq_r <= SIL;
        end
      endcase

      if (!w_valid) begin
        r_state <= ST_IDLE;
        r_done  <= 1'b0;
      end else if (w_restart || (r_state == ST_IDLE)) begin
        r_state    <= ST_LOAD;
        r_beat     <= '0;
        r_done     <= 1'b0;
        r_rom_rd   <= 1'b1;
        r_rom_addr <= ADDR_W'(TRK_BASE[track_sel]);
      end else begin
        case (r_state)
          ST_LOAD: r_state <= ST_WAIT;
          ST_WAIT: r_state <= ST_PLAY;
          ST_PLAY: begin
            if (w_wrap) begin
              if (r_beat < ADDR_W'(TRK_LEN[r_sel_prev] - 1)) begin
                r_state    <= ST_LOAD;
                r_beat     <= r_beat + 1'b1;
                r_rom_rd   <= 1'b1;
                r_rom_addr <= ADDR_W'(TRK_BASE[r_sel_prev]) + r_beat + 1'b1;
              end else if (TRK_LOOP[r_sel_prev]) begin
                r_state    <= ST_LOAD;
                r_beat     <= '0;
                r_rom_rd   <= 1'b1;
                r_rom_addr <= ADDR_W'(TRK_BASE[r_sel_prev]);
              end else begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign rom_rd     = r_rom_rd;
  assign rom_addr   = r_rom_addr;
  assign freqL      = r_freq_l;
  assign freqR      = r_freq_r;
  assign beat_tick  = w_tick;
  assign track_done = r_done;

endmodule

// File: doc/bgm_sequencer.md
BGM_SEQUENCER -- requirements
Module: bgm_sequencer

Interface
REQ-001 The block SHALL have the parameter NUM_TRACKS, default 8, giving the number of selectable tracks.
REQ-002 The block SHALL have the parameter ADDR_W, default 12, giving the note-ROM address width.
REQ-003 The block SHALL have the parameter FREQ_W, default 26, giving the tone word width.
REQ-004 The block SHALL have the parameter SILENCE, default 50000000, giving the tone word that means no sound.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-006 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have the port en, input, 1 bit: play enable.
REQ-008 The block SHALL have the port track_sel, input, $clog2(NUM_TRACKS) bits: selected track.
REQ-009 The block SHALL have the port mute, input, 1 bit: forces silence without stopping sequencing.
REQ-010 The block SHALL have the port rom_rd, output, 1 bit: note-ROM read strobe.
REQ-011 The block SHALL have the port rom_addr, output, ADDR_W bits: note-ROM address.
REQ-012 The block SHALL have the ports rom_toneL and rom_toneR, input, FREQ_W bits each: ROM data, valid exactly 1 cycle after rom_rd.
REQ-013 The block SHALL have the ports freqL and freqR, output, FREQ_W bits each: registered tone words.
REQ-014 The block SHALL have the port beat_tick, output, 1 bit: 1-cycle pulse at each beat boundary.
REQ-015 The block SHALL have the port track_done, output, 1 bit: high while a one-shot track has finished.

Function
REQ-016 Per-track constants SHALL be: BASE (ROM start address), LEN (beats, ≥1), DIV (clk cycles per beat, ≥4), LOOP (1 = loop, 0 = one-shot).
REQ-017 The FSM SHALL have the states IDLE, LOAD, WAIT, PLAY and DONE.
REQ-018 IDLE: freqL/R = SILENCE; go to LOAD with beat = 0 and divider = 0 when en = 1 and track_sel < NUM_TRACKS.
REQ-019 LOAD: rom_rd = 1 for exactly 1 cycle with rom_addr = BASE + beat; then go to WAIT.
REQ-020 WAIT: capture rom_toneL/R into freqL/R (visible the next cycle, unless muted); then go to PLAY.
REQ-021 The divider SHALL count 0..DIV-1 continuously through LOAD, WAIT and PLAY, so the beat period is exactly DIV cycles.
REQ-022 At divider = DIV-1: assert beat_tick for 1 cycle and wrap the divider to 0.
REQ-023 At a beat_tick, if beat < LEN-1: increment beat and go to LOAD.
REQ-024 At a beat_tick, if beat = LEN-1 and LOOP = 1: set beat = 0 and go to LOAD.
REQ-025 At a beat_tick, if beat = LEN-1 and LOOP = 0: go to DONE.
REQ-026 DONE: freqL/R = SILENCE, track_done = 1, no ROM reads; exit only on a restart or when en falls.
REQ-027 Restart: a change of track_sel, or a rising edge of en, SHALL clear beat and divider and go to LOAD on the next cycle, from any state.
REQ-028 A restart in the same cycle as a beat_tick SHALL win: the old track does not advance and no beat_tick is emitted.
REQ-029 en = 0, or track_sel ≥ NUM_TRACKS, SHALL send the FSM to IDLE on the next cycle; freqL/R = SILENCE the following cycle.
REQ-030 mute = 1 SHALL force freqL/R = SILENCE from the next cycle; beat position and divider keep running.
REQ-031 On mute falling, freqL/R SHALL return to the current beat's tone on the next cycle (the last captured tone is held internally).
REQ-032 The address computation BASE + beat SHALL be done in ADDR_W bits with no wrap; tables are constructed so that BASE + LEN ≤ 2^ADDR_W.

Reset
REQ-033 While rst = 0 the FSM SHALL be in IDLE, with beat = 0 and divider = 0.
REQ-034 While rst = 0 the outputs SHALL be: freqL/R = SILENCE, held tone = SILENCE, rom_rd = 0, rom_addr = 0, beat_tick = 0, track_done = 0.
REQ-035 Reset assertion mid-track SHALL abort immediately with no ROM read completing.
REQ-036 After reset is released, playback SHALL start per REQ-018 without needing a rising edge of en.

Structure
REQ-037 The package bgm_pkg SHALL hold the FSM state enum, SILENCE, and the per-track BASE/LEN/DIV/LOOP constant arrays indexed by track.
REQ-038 A sub-module bgm_beat_timer (divider plus beat_tick, with synchronous clear) SHALL be instantiated once; the note ROM stays external.

Verification
REQ-039 Track 0 (LEN = 3, DIV = 8, LOOP = 1), ROM = {A, B, C}, en = 1: freqL shows A, B, C, A at 8-cycle spacing; beat_tick fires every 8 cycles.
REQ-040 Track 1 (LEN = 2, LOOP = 0): after the 2nd beat_tick, track_done = 1, freqL/R = 50000000, and rom_rd stays 0.
REQ-041 Change track_sel 1→0 in the cycle where divider = DIV-1: no beat_tick; the next rom_rd has rom_addr = BASE[0].
REQ-042 Assert mute for 20 cycles mid-track: output = 50000000; at unmute, freqL shows the current beat's tone and beat_tick cadence is unbroken.
REQ-043 Set track_sel = NUM_TRACKS: IDLE, SILENCE on both outputs, rom_rd never asserted.
REQ-044 Drive rst low during WAIT: outputs reset values immediately; after release with en = 1, the first rom_rd has rom_addr = BASE[track_sel].
